// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the elastic skid pipeline stage.
//               Holds the stage state encoding and the default payload width.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Default payload width of a pipeline stage
  localparam int PIPE_WIDTH = 42;

  // Occupancy of the stage: EMPTY (nothing), BUSY (main only), FULL (main+skid)
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } pipe_state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_skid_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_slot
// Description : WIDTH-bit storage register with load enable and asynchronous
//               active-high reset to zero. Used for both the main (head) and
//               the skid entry of pipe_skid_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next value: take the new word on load, otherwise hold
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = d;
    end
  end

  // Storage flop, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_stage
// Description : Elastic valid/ready pipeline stage with a one-entry skid
//               buffer. in_ready is a pure function of the state register, so
//               backpressure never forms a combinational path across stages.
//               One cycle of latency, one transfer per cycle when unstalled.
//               Optional feature macro: PIPE_FLUSH_EN adds a synchronous flush
//               input that empties the stage.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
`ifdef PIPE_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  pipe_state_e      state_q;
  pipe_state_e      state_d;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_load;
  logic             w_skid_load;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  // Handshake flags are derived only from registered state and the inputs
  assign in_ready   = (state_q != FULL);
  assign out_valid  = (state_q != EMPTY);
  assign out_data   = w_main_q;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // Next-state and register-load decisions for the two-entry FIFO
  always_comb begin
    state_d     = state_q;
    w_main_load = 1'b0;
    w_skid_load = 1'b0;
    w_main_d    = in_data;
    case (state_q)
      EMPTY: begin
        if (w_in_fire) begin
          w_main_load = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (w_in_fire && w_out_fire) begin
          // Head leaves while the new beat takes its place
          w_main_load = 1'b1;
        end else if (w_in_fire) begin
          // Consumer stalled: park the in-flight beat in the skid register
          w_skid_load = 1'b1;
          state_d     = FULL;
        end else if (w_out_fire) begin
          state_d     = EMPTY;
        end
      end
      FULL: begin
        if (w_out_fire) begin
          // Promote the skid entry to head; in_ready is low so no input here
          w_main_load = 1'b1;
          w_main_d    = w_skid_q;
          state_d     = BUSY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
`ifdef PIPE_FLUSH_EN
    // Flush wins over everything; data registers keep their contents
    if (flush) begin
      state_d     = EMPTY;
      w_main_load = 1'b0;
      w_skid_load = 1'b0;
    end
`endif
  end

  // State register, emptied asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_skid_slot #(
    .WIDTH (WIDTH)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (w_main_load),
    .d     (w_main_d),
    .q     (w_main_q)
  );

  pipe_skid_slot #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (w_skid_load),
    .d     (in_data),
    .q     (w_skid_q)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_skid_stage
// Description : Self-checking bench for pipe_skid_stage. A capacity-two FIFO
//               queue serves as the reference model of the stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;

  localparam int W = 42;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;

  int errors = 0;
  int checks = 0;

  // Reference model contents and transfer logs
  logic [W-1:0] mq[$];
  logic [W-1:0] sent_q[$];
  logic [W-1:0] got_q[$];

  pipe_skid_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef PIPE_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock edge; the model is a FIFO holding at most two entries,
  // accepting only when it held fewer than two before the edge.
  task automatic tick();
    logic mi;
    logic mo;
    mo = out_ready && (mq.size() > 0);
    mi = in_valid && (mq.size() < 2);
    if (out_valid && out_ready) got_q.push_back(out_data);
    @(posedge clk);
    if (mo) void'(mq.pop_front());
    if (flush) begin
      mq.delete();
    end else if (mi) begin
      mq.push_back(in_data);
      sent_q.push_back(in_data);
    end
    #1;
  endtask

  task automatic clear_logs();
    sent_q.delete();
    got_q.delete();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== '0)    begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    mq.delete(); clear_logs();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    // Fill to FULL, then reset asynchronously mid-cycle
    in_valid = 1'b1; in_data = W'(42'h111); tick();
    in_data = W'(42'h222); tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    #3; reset = 1'b1; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== '0)    begin errors++; $display("FAIL async_reset_out_data got %h want 0", out_data); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL async_reset_in_ready got %b want 1", in_ready); end
    reset = 1'b0;
    mq.delete(); clear_logs();
    in_valid = 1'b1; in_data = W'(42'h33); out_ready = 1'b1; tick();
    in_valid = 1'b0; tick(); tick();
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL reset_first_xfer_count got %0d want 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== W'(42'h33)) begin errors++; $display("FAIL reset_first_xfer got %h want 33", got_q[0]); end
    end
  endtask

  task automatic test_streaming();
    drain(); clear_logs();
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; in_data = W'(i);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready beat %0d got %b want 1", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== W'(i)) begin
        errors++; $display("FAIL stream_out beat %0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, W'(i));
      end
    end
    in_valid = 1'b0; tick(); tick();
    checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL stream_count got %0d want 16", got_q.size()); end
    else begin
      for (int i = 0; i < 16; i++) begin
        checks++; if (got_q[i] !== W'(i + 1)) begin errors++; $display("FAIL stream_order idx %0d got %h want %h", i, got_q[i], W'(i + 1)); end
      end
    end
  endtask

  task automatic test_stall();
    drain(); clear_logs();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = W'(42'hA); tick();
    checks++; if (out_valid !== 1'b1 || out_data !== W'(42'hA)) begin errors++; $display("FAIL stall_head_a got v=%b d=%h want v=1 d=a", out_valid, out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_after_a got %b want 1", in_ready); end
    in_data = W'(42'hB); tick();
    checks++; if (out_data !== W'(42'hA)) begin errors++; $display("FAIL stall_hold_a got %h want a", out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_full got %b want 0", in_ready); end
    in_data = W'(42'hC); tick();
    checks++; if (out_data !== W'(42'hA) || in_ready !== 1'b0) begin errors++; $display("FAIL stall_blocked got d=%h r=%b want d=a r=0", out_data, in_ready); end
    out_ready = 1'b1; tick();
    checks++; if (out_data !== W'(42'hB) || in_ready !== 1'b1) begin errors++; $display("FAIL stall_skid_promote got d=%h r=%b want d=b r=1", out_data, in_ready); end
    tick();
    checks++; if (out_data !== W'(42'hC)) begin errors++; $display("FAIL stall_c_in got %h want c", out_data); end
    in_valid = 1'b0; tick(); tick();
    checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL stall_count got %0d want 3", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== W'(42'hA) || got_q[1] !== W'(42'hB) || got_q[2] !== W'(42'hC)) begin
        errors++; $display("FAIL stall_order got %h %h %h want a b c", got_q[0], got_q[1], got_q[2]);
      end
    end
  endtask

  task automatic test_bubble();
    logic exp_v [4];
    drain(); clear_logs();
    exp_v[0] = 1'b1; exp_v[1] = 1'b0; exp_v[2] = 1'b1; exp_v[3] = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = (i == 0) || (i == 2);
      in_data  = W'(42'h21 + i);
      tick();
      checks++; if (out_valid !== exp_v[i]) begin errors++; $display("FAIL bubble_valid cyc %0d got %b want %b", i, out_valid, exp_v[i]); end
    end
    in_valid = 1'b0; tick();
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL bubble_count got %0d want 2", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== W'(42'h21) || got_q[1] !== W'(42'h23)) begin
        errors++; $display("FAIL bubble_order got %h %h want 21 23", got_q[0], got_q[1]);
      end
    end
  endtask

  task automatic test_random();
    logic         hold;
    logic [W-1:0] held;
    int           bad;
    drain(); clear_logs();
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data   = {10'($urandom), 32'($urandom)};
      hold = out_valid && !out_ready;
      held = out_data;
      tick();
      checks++; if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2)) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_flags cyc %0d got v=%b r=%b want v=%b r=%b", i, out_valid, in_ready, mq.size() > 0, mq.size() < 2);
      end
      if (mq.size() > 0) begin
        checks++; if (out_data !== mq[0]) begin
          errors++; bad++;
          if (bad < 10) $display("FAIL rand_head cyc %0d got %h want %h", i, out_data, mq[0]);
        end
      end
      if (hold) begin
        checks++; if (out_data !== held) begin
          errors++; bad++;
          if (bad < 10) $display("FAIL rand_stable cyc %0d got %h want %h", i, out_data, held);
        end
      end
    end
    drain();
    checks++; if (got_q.size() !== sent_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", got_q.size(), sent_q.size()); end
    else begin
      for (int i = 0; i < got_q.size(); i++) begin
        if (got_q[i] !== sent_q[i]) begin
          checks++; errors++;
          $display("FAIL rand_order idx %0d got %h want %h", i, got_q[i], sent_q[i]);
          break;
        end
      end
    end
  endtask

`ifdef PIPE_FLUSH_EN
  task automatic test_flush();
    drain(); clear_logs();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = W'(42'h5); tick();
    in_data = W'(42'h6); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_prefull got r=%b want 0", in_ready); end
    flush = 1'b1; in_data = W'(42'h7); tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_empty got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    clear_logs();
    out_ready = 1'b1; tick(); tick(); tick();
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL flush_leak got %0d outputs want 0", got_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_bubble();
    test_random();
`ifdef PIPE_FLUSH_EN
    test_flush();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Elastic pipeline stage with valid/ready handshaking and a one-entry skid buffer. It carries backpressure upstream: the consumer's stall travels back to the producer through a registered ready, so the ready path does not combine combinationally across stages. It sits between pipeline stages wherever a downstream stage can stall. It sustains one transfer per cycle with one cycle of latency.

## Interface
- WIDTH, 42, payload width in bits
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  producer has data on in_data
- in_data  input  WIDTH  producer payload
- in_ready  output  1  stage can accept; depends only on state registers
- out_valid  output  1  out_data holds a valid entry
- out_data  output  WIDTH  head entry (main register)
- out_ready  input  1  consumer accepts head this cycle
- flush  input  1  synchronous discard of all entries (only with PIPE_FLUSH_EN)

## Operation
- Handshakes:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- Storage: main register (drives out_data) and skid register; 2-bit state from pipe_pkg.
- States:
  - EMPTY: no entries.
  - BUSY: main register valid.
  - FULL: main and skid registers valid.
- Outputs:
  - out_valid = (state != EMPTY)
  - in_ready = (state != FULL)
- EMPTY:
  - in_fire: main <= in_data, go to BUSY.
  - Otherwise: hold.
- BUSY:
  - in_fire & out_fire: main <= in_data, stay BUSY.
  - in_fire & !out_fire: skid <= in_data, go to FULL.
  - !in_fire & out_fire: go to EMPTY.
  - Neither: hold.
- FULL:
  - in_ready = 0, so no input is accepted.
  - out_fire: main <= skid, go to BUSY.
  - Otherwise: hold.
- Ordering is strict FIFO. No entry is dropped or duplicated except by flush.
- out_data holds its value while out_valid=1 and out_ready=0.
- The stage tolerates in_valid deasserting without a transfer; it never requires valid to be held.
- out_data in EMPTY: the last main value (don't-care for consumers).

## Timing
- Reset values:
  - state = EMPTY
  - out_valid = 0
  - out_data = 0
  - skid = 0
  - in_ready = 1, both during and after reset
- Latency: data accepted on edge N appears on out_data with out_valid=1 after edge N, so the consumer can take it on edge N+1.
- Throughput: 1 per cycle while out_ready=1.
- in_ready falls the cycle after the first stalled acceptance. The skid register absorbs that one in-flight beat.
- in_ready rises the cycle after the out_fire that drains FULL.
- A reset asserted mid-transfer discards all entries immediately, without waiting for a clock edge.

## Configuration
- PIPE_FLUSH_EN defined:
  - flush port is present.
  - flush=1 at an edge forces the state to EMPTY.
  - Any simultaneous in_fire is discarded.
  - Flush has priority over all other transitions.
  - Data registers are not cleared.
  - out_fire in the same cycle still counts as a completed transfer for the consumer.
- PIPE_FLUSH_EN undefined: flush port and logic are absent; behaviour is otherwise identical.

## Structure
- pipe_pkg holds:
  - the state typedef (EMPTY=2'b00, BUSY=2'b01, FULL=2'b10)
  - the default width constant PIPE_WIDTH=42
- Sub-module pipe_skid_slot: a WIDTH-bit register with load enable and asynchronous reset to 0. It is instantiated twice, once for main and once for skid.
- The next-state and enable logic lives in pipe_skid_stage.

## Test plan
- Reset: assert reset mid-cycle while FULL. Required: out_valid=0, out_data=0, in_ready=1 immediately; first transfer after release is the next accepted value.
- Streaming: out_ready=1, push 0x1 to 0x10 on consecutive cycles. Required: out_data 0x1 to 0x10 on consecutive cycles, one cycle after each input, with in_ready=1 throughout.
- Stall/skid: push 0xA, 0xB, 0xC with out_ready=0. Required:
  - 0xA is held on out_data.
  - 0xB is captured in skid.
  - in_ready=0 before 0xC is accepted.
  - After out_ready=1, the output sequence is 0xA, 0xB, 0xC.
- Random stalls: 1000 random in_valid/out_ready patterns. Required: output sequence equals input sequence, and out_data is stable whenever out_valid & !out_ready.
- Bubble: in_valid toggles 1,0,1 with out_ready=1. Required: out_valid shows 1,0,1 delayed by one cycle, with no duplicate outputs.
- Flush (PIPE_FLUSH_EN): FULL with 0x5, 0x6; assert flush together with in_valid=1 and data 0x7. Required: next cycle EMPTY, out_valid=0, and 0x7 is never output.
